// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: widths and FSM state type.
package serializer_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 5;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/word_serializer_mux.sv
// ThirtyTwoToOneMux: picks one bit of a 32-bit word by a 5-bit selector.
module ThirtyTwoToOneMux
  import serializer_pkg::*;
(
  input  logic [WORD_W-1:0] input_lines,
  input  logic [SEL_W-1:0]  selector_bits,
  output logic              output_line
);

  // Plain indexed select; every selector value addresses a real bit.
  always_comb output_line = input_lines[selector_bits];

endmodule

// File: rtl/word_serializer.sv
// word_serializer: accepts a 32-bit word plus length and shifts it out one
// bit per handshake, optionally followed by GAP_CYCLES idle cycles.
// Bit order: LSB first by default; define SERIALIZER_MSB_FIRST_EN to start at
// bit in_len and count down to bit 0 instead.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | presenting data_q[sel_q]; back-to-back reload when GAP_CYCLES = 0
// GAP   | GAP_CYCLES quiet cycles after a word, no input accepted
module word_serializer
  import serializer_pkg::*;
#(
  parameter int GAP_CYCLES = 0
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              busy
);

  // Gap counter counts down to zero, so it is loaded with one less than the gap.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  ser_state_t        stateQ;
  ser_state_t        stateNext;
  logic [WORD_W-1:0] data_q;
  logic [SEL_W-1:0]  len_q;
  logic [SEL_W-1:0]  sel_q;
  logic [GAP_W-1:0]  gapCnt;

  logic [SEL_W-1:0]  startSel;
  logic [SEL_W-1:0]  endSel;
  logic [SEL_W-1:0]  nextSel;
  logic              isLast;
  logic              muxBit;
  logic              loadWord;
  logic              stepSel;
  logic              loadGap;

`ifdef SERIALIZER_MSB_FIRST_EN
  assign startSel = in_len;
  assign endSel   = '0;
  assign nextSel  = sel_q - 1'b1;
`else
  assign startSel = '0;
  assign endSel   = len_q;
  assign nextSel  = sel_q + 1'b1;
`endif

  assign isLast = (sel_q == endSel);

  ThirtyTwoToOneMux uMux (
    .input_lines   (data_q),
    .selector_bits (sel_q),
    .output_line   (muxBit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    stateNext = stateQ;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    loadWord  = 1'b0;
    stepSel   = 1'b0;
    loadGap   = 1'b0;
    case (stateQ)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          loadWord  = 1'b1;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!isLast) begin
            stepSel = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            // Last bit leaves this cycle, so a new word can be taken without a bubble.
            in_ready = 1'b1;
            if (in_valid) begin
              loadWord = 1'b1;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            loadGap   = 1'b1;
            stateNext = GAP;
          end
        end
      end
      GAP: begin
        if (gapCnt == '0) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy     = (stateQ != IDLE);
  assign out_bit  = out_valid & muxBit;
  assign out_last = out_valid & isLast;

  // Word capture, bit selector stepping and gap timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      len_q  <= '0;
      sel_q  <= '0;
      gapCnt <= '0;
    end else begin
      if (loadWord) begin
        data_q <= in_data;
        len_q  <= in_len;
        sel_q  <= startSel;
      end else if (stepSel) begin
        sel_q <= nextSel;
      end
      if (loadGap) begin
        gapCnt <= GAP_LOAD;
      end else if ((stateQ == GAP) && (gapCnt != '0)) begin
        gapCnt <= gapCnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer: two instances (GAP_CYCLES = 0 and 3), each
// with its own driver, out_ready generator and scoreboard monitor.
module tb_word_serializer;
  import serializer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int GAP = (g == 0) ? 0 : 3;

    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic [4:0]  inLen;
    logic        outValid;
    logic        outReady;
    logic        outBit;
    logic        outLast;
    logic        busy;

    int          readyMode;
    bit          done;
    logic [1:0]  expQ[$];
    int          gapExp;
    bit          expIdle;
    bit          expValid;

    word_serializer #(.GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .reset_n   (rstN),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .in_len    (inLen),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_bit   (outBit),
      .out_last  (outLast),
      .busy      (busy)
    );

    // out_ready generator: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
      logic [3:0] patt;
      int ph;
      patt = 4'b1001;
      ph = 0;
      outReady = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        case (readyMode)
          1: begin
            outReady = patt[ph];
            ph = (ph + 1) % 4;
          end
          2: outReady = 1'($urandom_range(0, 1));
          default: begin
            outReady = 1'b1;
            ph = 0;
          end
        endcase
      end
    end

    // Scoreboard monitor: samples on the falling edge, pushes expected bits on
    // accepted words and pops on every output handshake.
    always @(negedge clk) begin : mon
      bit         hsIn;
      bit         wasLast;
      logic [1:0] fr;
      int         idx;
      if (!rstN) begin
        expQ.delete();
        gapExp   = 0;
        expValid = 0;
        expIdle  = 1;
        check($sformatf("gap%0d reset_out_valid", GAP), outValid, 0);
        check($sformatf("gap%0d reset_busy", GAP), busy, 0);
        check($sformatf("gap%0d reset_out_bit", GAP), {outLast, outBit}, 0);
      end else begin
        hsIn    = inValid && inReady;
        wasLast = 0;
        if (expValid) begin
          check($sformatf("gap%0d valid_after_accept", GAP), outValid, 1);
          expValid = 0;
        end
        if (gapExp > 0) begin
          check($sformatf("gap%0d gap_out_valid", GAP), outValid, 0);
          check($sformatf("gap%0d gap_in_ready", GAP), inReady, 0);
          check($sformatf("gap%0d gap_busy", GAP), busy, 1);
          gapExp--;
          if (gapExp == 0) expIdle = 1;
        end else if (expIdle) begin
          check($sformatf("gap%0d idle_in_ready", GAP), inReady, 1);
          check($sformatf("gap%0d idle_busy", GAP), busy, 0);
          expIdle = 0;
        end
        if (outValid) begin
          if (expQ.size() == 0) begin
            check($sformatf("gap%0d unexpected_valid", GAP), outValid, 0);
          end else begin
            fr = expQ[0];
            check($sformatf("gap%0d bit_last", GAP), {outLast, outBit}, fr);
            check($sformatf("gap%0d shift_in_ready", GAP), inReady,
                  ((GAP == 0) && outReady && fr[1]) ? 1 : 0);
            if (outReady) begin
              void'(expQ.pop_front());
              wasLast = fr[1];
            end
          end
        end else begin
          check($sformatf("gap%0d idle_bit_last_zero", GAP), {outLast, outBit}, 0);
        end
        if (wasLast && !hsIn) begin
          if (GAP > 0) gapExp = GAP;
          else expIdle = 1;
        end
        if (hsIn) begin
          for (int i = 0; i <= int'(inLen); i++) begin
`ifdef SERIALIZER_MSB_FIRST_EN
            idx = int'(inLen) - i;
`else
            idx = i;
`endif
            expQ.push_back({(i == int'(inLen)), inData[idx]});
          end
          expValid = 1;
        end
      end
    end

    task automatic sendWord(input logic [31:0] d, input logic [4:0] l);
      int budget;
      bit acc;
      inValid = 1'b1;
      inData  = d;
      inLen   = l;
      budget  = 0;
      acc     = 0;
      while (!acc && budget < 300) begin
        @(negedge clk);
        acc = inReady;
        @(posedge clk);
        #1;
        budget++;
      end
      check($sformatf("gap%0d accept_timeout", GAP), acc, 1);
      inValid = 1'b0;
    endtask

    task automatic waitIdle();
      int b;
      b = 0;
      while ((busy || expQ.size() != 0) && b < 600) begin
        @(posedge clk);
        #1;
        b++;
      end
      check($sformatf("gap%0d drain", GAP), (busy || expQ.size() != 0), 0);
    endtask

    // Stimulus: directed words, back-to-back pair, random words, mid-word reset.
    initial begin
      rstN      = 1'b0;
      inValid   = 1'b0;
      inData    = '0;
      inLen     = '0;
      readyMode = 0;
      done      = 0;
      repeat (3) @(posedge clk);
      #2 rstN = 1'b1;
      @(posedge clk);
      #1;
      sendWord(32'hA5A5_0003, 5'd3);
      waitIdle();
      sendWord(32'h0000_0001, 5'd0);
      waitIdle();
      readyMode = 1;
      sendWord(32'h8000_0001, 5'd31);
      waitIdle();
      readyMode = 0;
      sendWord(32'h1234_5678, 5'd7);
      sendWord(32'hCAFE_F00D, 5'd5);
      waitIdle();
      readyMode = 2;
      repeat (25) begin
        sendWord($urandom, 5'($urandom_range(0, 31)));
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        end
      end
      waitIdle();
      readyMode = 0;
      sendWord(32'hFFFF_FFFF, 5'd31);
      repeat (10) @(posedge clk);
      #3 rstN = 1'b0;
      #1;
      check($sformatf("gap%0d async_reset_valid", GAP), outValid, 0);
      check($sformatf("gap%0d async_reset_busy", GAP), busy, 0);
      check($sformatf("gap%0d async_reset_bit", GAP), {outLast, outBit}, 0);
      @(posedge clk);
      #2 rstN = 1'b1;
      @(posedge clk);
      #1;
      sendWord(32'h0000_0005, 5'd2);
      waitIdle();
      done = 1;
    end
  end

  initial begin
    int b;
    b = 0;
    while (!(lane[0].done && lane[1].done) && b < 20000) begin
      @(posedge clk);
      b++;
    end
    if (!(lane[0].done && lane[1].done)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: lanes done %0d %0d, required 1 1", lane[0].done, lane[1].done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
